// File: rtl/axi_stream_capture_ctrl.sv
// Packetising capture controller between a free-running AXI4-Stream source and the DMA stream slave.
// Define CAPTURE_CTRL_STATS_EN to add the stall/back-pressure statistics counters.
module axi_stream_capture_ctrl #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [LEN_W-1:0]  cfg_pkt_words,
    input  logic [CNT_W-1:0]  cfg_num_pkts,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_abort,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              sts_busy,
    output logic              sts_done,
    output logic              sts_aborted,
    output logic [CNT_W-1:0]  sts_pkt_count
`ifdef CAPTURE_CTRL_STATS_EN
    ,
    output logic [31:0]       sts_stall_cycles,
    output logic [31:0]       sts_bp_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [LEN_W-1:0]  r_pktLen;
    logic [LEN_W-1:0]  r_beatCnt;
    logic [CNT_W-1:0]  r_numPkts;
    logic [CNT_W-1:0]  r_pktsCaptured;
    logic [CNT_W-1:0]  r_pktCount;
    logic              r_stopPend;
    logic              r_aborted;
    logic              r_done;
    logic              r_mValid;
    logic              r_mLast;
    logic [DATA_W-1:0] r_mData;

    logic [LEN_W-1:0]  w_cfgLen;
    logic              w_startAcc;
    logic              w_acceptEn;
    logic              w_sReady;
    logic              w_capture;
    logic              w_naturalLast;
    logic              w_beatLast;
    logic              w_lastPkt;
    logic              w_forceLast;
    logic              w_mXfer;

    assign w_cfgLen      = (cfg_pkt_words == '0) ? LEN_W'(1) : cfg_pkt_words;
    assign w_startAcc    = (r_state == IDLE) && ctrl_start;
    assign w_naturalLast = (r_beatCnt == (r_pktLen - LEN_W'(1)));
    assign w_beatLast    = (r_state == ABORT) || w_naturalLast;
    assign w_lastPkt     = (r_numPkts != '0) && (r_pktsCaptured == (r_numPkts - CNT_W'(1)));
    assign w_mXfer       = r_mValid && m_axis_tready;

    // A held open beat can only be closed in place if the DMA is not taking it this cycle.
    assign w_forceLast = (r_state == ABORT) && r_mValid && !r_mLast && !m_axis_tready;
    assign w_acceptEn  = (r_state == RUN) ||
                         ((r_state == ABORT) && !w_forceLast && (r_beatCnt != '0));
    assign w_sReady    = w_acceptEn && (!r_mValid || m_axis_tready);
    assign w_capture   = s_axis_tvalid && w_sReady;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (ctrl_start) w_nextState = RUN;
            end
            RUN: begin
                if (ctrl_abort) begin
                    w_nextState = (w_capture && w_naturalLast) ? DRAIN : ABORT;
                end else if (w_capture && w_naturalLast && (w_lastPkt || r_stopPend || ctrl_stop)) begin
                    w_nextState = DRAIN;
                end else if (ctrl_stop && (r_beatCnt == '0) && !w_capture) begin
                    w_nextState = DRAIN;
                end
            end
            ABORT: begin
                if (w_forceLast) begin
                    w_nextState = DRAIN;
                end else if (r_beatCnt != '0) begin
                    if (w_capture) w_nextState = DRAIN;
                end else begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_mValid) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pktLen       <= '0;
            r_numPkts      <= '0;
            r_beatCnt      <= '0;
            r_pktsCaptured <= '0;
            r_stopPend     <= 1'b0;
            r_aborted      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if (w_startAcc) begin
                r_pktLen       <= w_cfgLen;
                r_numPkts      <= cfg_num_pkts;
                r_beatCnt      <= '0;
                r_pktsCaptured <= '0;
                r_stopPend     <= 1'b0;
                r_aborted      <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_beatCnt <= w_beatLast ? '0 : r_beatCnt + LEN_W'(1);
                    if (w_beatLast) r_pktsCaptured <= r_pktsCaptured + CNT_W'(1);
                end
                if ((r_state == RUN) && ctrl_stop) r_stopPend <= 1'b1;
                if ((r_state == RUN) && ctrl_abort) r_aborted <= 1'b1;
            end
            r_done <= (r_state == DRAIN) && !r_mValid;
        end
    end

    // Single output register stage; tlast is decided at capture time.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
            r_mData  <= '0;
        end else begin
            if (w_capture) begin
                r_mValid <= 1'b1;
                r_mLast  <= w_beatLast;
                r_mData  <= s_axis_tdata;
            end else if (w_forceLast) begin
                r_mLast <= 1'b1;
            end else if (m_axis_tready) begin
                r_mValid <= 1'b0;
                r_mLast  <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pktCount <= '0;
        end else if (w_startAcc) begin
            r_pktCount <= '0;
        end else if (w_mXfer && r_mLast) begin
            r_pktCount <= r_pktCount + CNT_W'(1);
        end
    end

`ifdef CAPTURE_CTRL_STATS_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_bpCycles;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stallCycles <= '0;
            r_bpCycles    <= '0;
        end else if (w_startAcc) begin
            r_stallCycles <= '0;
            r_bpCycles    <= '0;
        end else begin
            if ((r_state == RUN) && !s_axis_tvalid && (!r_mValid || m_axis_tready) &&
                (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (r_mValid && !m_axis_tready && (r_bpCycles != '1)) begin
                r_bpCycles <= r_bpCycles + 32'd1;
            end
        end
    end

    assign sts_stall_cycles = r_stallCycles;
    assign sts_bp_cycles    = r_bpCycles;
`endif

    assign s_axis_tready = w_sReady;
    assign m_axis_tvalid = r_mValid;
    assign m_axis_tdata  = r_mData;
    assign m_axis_tlast  = r_mLast;
    assign sts_busy      = (r_state != IDLE);
    assign sts_done      = r_done;
    assign sts_aborted   = r_aborted;
    assign sts_pkt_count = r_pktCount;

endmodule
